bsg_manycore_barrier_edge_root: RTL and testbench

BSG_MANYCORE_BARRIER_EDGE_ROOT -- requirements
Module: bsg_manycore_barrier_edge_root

---
 rtl/bsg_manycore_barrier_edge_root.sv | 121 ++++++++++++
 tb/tb_bsg_manycore_barrier_edge_root.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_barrier_edge_root.sv
// Edge-of-array barrier root: collects sense-reversal arrivals from each row,
// releases all rows with a new sense, and counts completed barriers.
module bsg_manycore_barrier_edge_root
  #(parameter int num_links_p   = 4
   ,parameter int in_stages_p   = 1
   ,parameter int out_stages_p  = 1
   ,parameter int epoch_width_p = 16
   )
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic [num_links_p-1:0]   barrier_link_i
  ,output logic [num_links_p-1:0]   barrier_link_o
  ,input  logic [num_links_p-1:0]   link_mask_i
  ,output logic                     barrier_done_o
  ,output logic [epoch_width_p-1:0] epoch_o
  ,output logic                     error_o
  );

  typedef enum logic {COLLECT, RELEASE} state_e;

  state_e                   state_r, state_n;
  logic                     sense_r;
  logic [num_links_p-1:0]   out_r;
  logic [num_links_p-1:0]   arrived_r;
  logic [epoch_width_p-1:0] epoch_r;
  logic                     error_r;

  logic [num_links_p-1:0]   link_ret;
  logic [num_links_p-1:0]   sense_vec;
  logic [num_links_p-1:0]   arrive_now;
  logic [num_links_p-1:0]   returned;
  logic                     complete;

  // Input retiming chain
  if (in_stages_p == 0) begin : g_in_comb
    assign link_ret = barrier_link_i;
  end else begin : g_in_pipe
    logic [in_stages_p-1:0][num_links_p-1:0] in_q;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        in_q <= '0;
      end else begin
        in_q[0] <= barrier_link_i;
        for (int unsigned s = 1; s < unsigned'(in_stages_p); s++) begin
          in_q[s] <= in_q[s-1];
        end
      end
    end
    assign link_ret = in_q[in_stages_p-1];
  end

  // Output retiming chain
  if (out_stages_p == 0) begin : g_out_comb
    assign barrier_link_o = out_r;
  end else begin : g_out_pipe
    logic [out_stages_p-1:0][num_links_p-1:0] out_q;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        out_q <= '0;
      end else begin
        out_q[0] <= out_r;
        for (int unsigned s = 1; s < unsigned'(out_stages_p); s++) begin
          out_q[s] <= out_q[s-1];
        end
      end
    end
    assign barrier_link_o = out_q[out_stages_p-1];
  end

  assign sense_vec  = {num_links_p{sense_r}};
  assign arrive_now = link_mask_i & (link_ret ^ sense_vec);
  // A masked link that had arrived and now matches the sense again has backed out.
  assign returned   = link_mask_i & arrived_r & ~(link_ret ^ sense_vec);
  assign complete   = (state_r == COLLECT) && (|link_mask_i)
                      && (&(arrive_now | ~link_mask_i));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      COLLECT: if (complete) state_n = RELEASE;
      RELEASE: state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sense_r   <= 1'b0;
      out_r     <= '0;
      arrived_r <= '0;
      epoch_r   <= '0;
      error_r   <= 1'b0;
    end else if (state_r == COLLECT) begin
      if (complete) begin
        sense_r   <= ~sense_r;
        out_r     <= ~sense_vec;
        arrived_r <= '0;
        epoch_r   <= epoch_r + 1'b1;
      end else begin
        // Unmasking a link drops its arrival so it cannot later flag an error.
        arrived_r <= (arrived_r & link_mask_i) | arrive_now;
        if (|returned) error_r <= 1'b1;
      end
    end else begin
      arrived_r <= '0;
    end
  end

  assign barrier_done_o = (state_r == RELEASE) && !reset_i;
  assign epoch_o        = epoch_r;
  assign error_o        = error_r;

endmodule

// File: tb/tb_bsg_manycore_barrier_edge_root.sv
// Self-checking bench: directed barrier scenarios plus random arrivals, compared
// every cycle against an arrival/release reference model.
module tb_bsg_manycore_barrier_edge_root;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  barrier_link_i = '0;
  logic [3:0]  link_mask_i = '0;
  logic [3:0]  link_o, link_o_w;
  logic        done, done_w, err, err_w;
  logic [15:0] epoch;
  logic [1:0]  epoch_w;

  always #5 clk = ~clk;

  bsg_manycore_barrier_edge_root #(
    .num_links_p(4), .in_stages_p(1), .out_stages_p(1), .epoch_width_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .barrier_link_i(barrier_link_i),
    .barrier_link_o(link_o), .link_mask_i(link_mask_i),
    .barrier_done_o(done), .epoch_o(epoch), .error_o(err)
  );

  bsg_manycore_barrier_edge_root #(
    .num_links_p(4), .in_stages_p(1), .out_stages_p(1), .epoch_width_p(2)
  ) dut_w (
    .clk_i(clk), .reset_i(reset_i), .barrier_link_i(barrier_link_i),
    .barrier_link_o(link_o_w), .link_mask_i(link_mask_i),
    .barrier_done_o(done_w), .epoch_o(epoch_w), .error_o(err_w)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: what the barrier should show in the current cycle.
  bit       m_rel;      // this cycle is the release cycle
  bit       m_sense;    // current sense
  bit       m_osense;   // level now visible on barrier_link_o
  int       m_ep;       // barriers completed since reset
  bit       m_err;
  bit [3:0] m_arr;      // links known to have arrived this barrier
  bit [3:0] m_seen;     // input level as seen after input retiming

  task automatic model_step(input logic [3:0] in_v, input logic [3:0] mask_v, input logic rst_v);
    bit all_in;
    bit [3:0] now_in;
    if (rst_v) begin
      m_rel = 0; m_sense = 0; m_osense = 0; m_ep = 0; m_err = 0; m_arr = '0; m_seen = '0;
      return;
    end
    m_osense = m_sense;
    if (m_rel) begin
      m_rel = 0;
    end else begin
      all_in = (mask_v != 0);
      for (int i = 0; i < 4; i++) begin
        now_in[i] = mask_v[i] && (m_seen[i] != m_sense);
        if (mask_v[i] && !now_in[i]) all_in = 0;
      end
      if (all_in) begin
        m_rel = 1; m_sense = !m_sense; m_ep++; m_arr = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (mask_v[i] && m_arr[i] && (m_seen[i] == m_sense)) m_err = 1;
          m_arr[i] = mask_v[i] && (m_arr[i] || now_in[i]);
        end
      end
    end
    m_seen = in_v;
  endtask

  task automatic cycle(input logic [3:0] in_v, input logic [3:0] mask_v, input logic rst_v);
    @(posedge clk); #1;
    barrier_link_i = in_v;
    link_mask_i    = mask_v;
    reset_i        = rst_v;
    #1;
    check("done",    {31'd0, done},   {31'd0, m_rel && !rst_v});
    check("done_w",  {31'd0, done_w}, {31'd0, m_rel && !rst_v});
    check("epoch",   {16'd0, epoch},  32'(m_ep) & 32'hFFFF);
    check("epoch_w", {30'd0, epoch_w}, 32'(m_ep) & 32'h3);
    check("error",   {31'd0, err},    {31'd0, m_err});
    check("link_o",  {28'd0, link_o}, {28'd0, {4{m_osense}}});
    model_step(in_v, mask_v, rst_v);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(4'h0, 4'hF, 1'b1);
  endtask

  logic [3:0] cur, msk, v;

  initial begin
    model_step(4'h0, 4'h0, 1'b1);
    repeat (2) @(posedge clk);

    // Reset state
    do_reset(2);
    cycle(4'h0, 4'hF, 1'b0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_epoch", {16'd0, epoch}, 32'd0);
    check("rst_link_o", {28'd0, link_o}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Basic completion, all links at once
    repeat (5) cycle(4'h0, 4'hF, 1'b0);
    cycle(4'hF, 4'hF, 1'b0);
    cycle(4'hF, 4'hF, 1'b0);
    check("basic_no_early_done", {31'd0, done}, 32'd0);
    cycle(4'hF, 4'hF, 1'b0);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_epoch", {16'd0, epoch}, 32'd1);
    cycle(4'hF, 4'hF, 1'b0);
    check("basic_link_o", {28'd0, link_o}, 32'hF);
    check("basic_done_once", {31'd0, done}, 32'd0);
    repeat (3) cycle(4'hF, 4'hF, 1'b0);
    check("stale_no_done", {31'd0, done}, 32'd0);

    // Second epoch, sense reversed
    cycle(4'h0, 4'hF, 1'b0);
    cycle(4'h0, 4'hF, 1'b0);
    cycle(4'h0, 4'hF, 1'b0);
    check("ep2_done", {31'd0, done}, 32'd1);
    check("ep2_epoch", {16'd0, epoch}, 32'd2);
    cycle(4'h0, 4'hF, 1'b0);
    check("ep2_link_o", {28'd0, link_o}, 32'h0);

    // Staggered arrivals, partial mask
    do_reset(2);
    repeat (4) cycle(4'h0, 4'h5, 1'b0);
    repeat (15) cycle(4'h1, 4'h5, 1'b0);
    check("stagger_wait", {31'd0, done}, 32'd0);
    cycle(4'h5, 4'h5, 1'b0);
    cycle(4'h5, 4'h5, 1'b0);
    cycle(4'h5, 4'h5, 1'b0);
    check("stagger_done", {31'd0, done}, 32'd1);
    check("stagger_epoch", {16'd0, epoch}, 32'd1);

    // Error detection, then a completion regardless
    do_reset(2);
    repeat (2) cycle(4'h0, 4'hF, 1'b0);
    repeat (3) cycle(4'h2, 4'hF, 1'b0);
    repeat (3) cycle(4'h0, 4'hF, 1'b0);
    check("err_set", {31'd0, err}, 32'd1);
    repeat (3) cycle(4'hF, 4'hF, 1'b0);
    check("err_epoch", {16'd0, epoch}, 32'd1);
    repeat (3) cycle(4'hF, 4'hF, 1'b0);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Unmasking an arrived link mid-collection is not an error
    do_reset(2);
    repeat (3) cycle(4'h8, 4'hF, 1'b0);
    repeat (3) cycle(4'h0, 4'h7, 1'b0);
    repeat (3) cycle(4'h0, 4'hF, 1'b0);
    check("unmask_no_err", {31'd0, err}, 32'd0);

    // All-zero mask never completes
    for (int i = 0; i < 12; i++) cycle(4'(i), 4'h0, 1'b0);
    check("mask0_epoch", {16'd0, epoch}, 32'd0);

    // Reset mid-collection discards the barrier
    do_reset(1);
    repeat (4) cycle(4'h7, 4'hF, 1'b0);
    do_reset(2);
    repeat (2) cycle(4'h0, 4'hF, 1'b0);
    check("midrst_epoch", {16'd0, epoch}, 32'd0);
    check("midrst_link_o", {28'd0, link_o}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);

    // Epoch wrap on the narrow-counter instance
    v = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      v = ~v;
      repeat (3) cycle(v, 4'hF, 1'b0);
      check("wrap_epoch_w", {30'd0, epoch_w}, 32'(k % 4));
    end

    // Random arrivals, occasional misbehaviour, mask changes and resets
    do_reset(2);
    cur = '0;
    msk = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (cur[i] == m_sense && $urandom_range(0, 3) == 0) cur[i] = !m_sense;
        else if ($urandom_range(0, 63) == 0) cur[i] = !cur[i];
      end
      if ($urandom_range(0, 59) == 0) msk = 4'($urandom_range(0, 15));
      cycle(cur, msk, $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
